cnn_classifier_engine: RTL
==========================

Name: cnn_classifier_engine

Overview:
Parametrised successor of the single-kernel CNN classifier. Accepts one KxK image window per feature-map pixel over a valid/ready handshake, computes a signed convolution with ReLU and requantisation, and buffers the feature map. It then runs a sequential fully-connected layer (one MAC per cycle) followed by a running argmax, and reports the class index with a DONE pulse. Conv and FC weights are loaded at run time through a write port instead of being fixed constants.

Parameters:
K, 5, kernel side; window is K*K pixels
DW, 8, pixel / feature / weight width
FMAP, 24, feature-map side; FEAT = FMAP*FMAP entries
NCLASS, 10, FC outputs / classes
ACC_W, 32, signed accumulator width
SHIFT, 0, arithmetic right shift applied to conv sum before saturation

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
START  in  1  begin a classification (sampled in IDLE only)
WIN_VALID  in  1  window present on WIN
WIN_READY  out  1  engine accepts a window this cycle
WIN  in  K*K*DW  unsigned pixels, pixel (r,c) at bits [(r*K+c)*DW +: DW]
W_WE  in  1  weight write strobe (honoured in IDLE only)
W_SEL  in  1  0 = conv weight, 1 = FC weight
W_ADDR  in  clog2(NCLASS*FEAT)  conv: r*K+c; FC: class*FEAT+feature
W_DATA  in  DW  signed two's-complement weight
BUSY  out  1  high outside IDLE
DONE  out  1  one-cycle pulse when OUT becomes valid
OUT  out  clog2(NCLASS)  winning class index

Behaviour:
- One clock CLK; reset nRST is asynchronous and active-low. On reset: state=IDLE, DONE=0, OUT=0, BUSY=0, WIN_READY=0, and all counters are cleared. Weight memories are not cleared.
- States: IDLE -> CONV -> FC -> ARGMAX_DONE -> IDLE.
- IDLE: START=1 -> CONV with conv_cnt=0. W_WE writes the selected weight memory in the same edge. If START and W_WE arrive in the same cycle, the write happens and START is also taken. W_WE outside IDLE is ignored.
- CONV: WIN_READY=1. Each cycle with WIN_VALID&&WIN_READY:
  - sum = Σ signed(w[r][c]) * unsigned(pix[r][c]), computed at ACC_W width.
  - ReLU: a negative sum becomes 0.
  - The result is shifted right by SHIFT, saturated to [0, 2^DW-1], and written to feat[conv_cnt].
  - conv_cnt increments.
  - When the accepted window is number FEAT-1: go to FC, WIN_READY drops on the next cycle, and no further window is accepted.
  - WIN_VALID=0 stalls with no state change.
- FC: class i from 0 to NCLASS-1, feature j from 0 to FEAT-1, one MAC per cycle: acc += signed(fcw[i*FEAT+j]) * unsigned(feat[j]).
  - acc resets to 0 at j=0 for each class.
  - At j=FEAT-1 the final acc is compared against best. Update when i==0 or acc > best (signed, strict), so ties resolve to the lowest index. best_idx is set to i.
  - After class NCLASS-1 -> ARGMAX_DONE.
  - FC latency is exactly NCLASS*FEAT cycles.
- ARGMAX_DONE: OUT <= best_idx, DONE <= 1 for exactly one cycle, then -> IDLE. OUT holds until the next DONE.
- START outside IDLE is ignored. A new START in the cycle after DONE is accepted.
- Accumulators do not saturate; ACC_W must cover K*K*2^(2DW) and FEAT*2^(2DW) (default 32 bits is sufficient).
- Reset mid-CONV or mid-FC aborts immediately. No DONE is produced, and OUT returns to 0.

Decomposition:
- Shared package cnn_pkg holds:
  - state encoding (IDLE, CONV, FC, ARGMAX_DONE)
  - derived constants FEAT, W_ADDR width, OUT width (clog2)
  - the saturate/ReLU function
- One sub-module, cnn_conv_window: purely combinational KxK signed MAC tree plus ReLU/shift/saturate, instantiated once in the top level.
- FC MAC, argmax, feature buffer, weight memories and FSM stay in the top level.

Test Plan:
- Reset/idle: assert nRST=0 mid-CONV after 10 windows. Expect DONE=0, OUT=0, BUSY=0 immediately. A subsequent full run classifies correctly.
- Conv arithmetic (K=3, FMAP=2, NCLASS=3):
  - All conv weights +1 with all pixels 10 -> feat=90.
  - Centre weight -1, others 0, with pixels 200 -> ReLU gives feat=0.
  - SHIFT=0 with sum 2295 -> saturates to feat=255.
- FC/argmax (K=3, FMAP=2, NCLASS=3, feat all 1): FC weights of class 0,1,2 = 1,5,3 each -> OUT=1, DONE pulses once exactly 4*3=12 cycles after the last window is accepted.
- Tie and negatives: class scores -8,-8,-20 -> OUT=0. Scores 7,7,7 -> OUT=0.
- Handshake: toggle WIN_VALID every other cycle. Expect exactly FEAT accepted windows, and WIN_READY=0 after the last one. START pulsed during FC is ignored, and W_WE during CONV leaves the weights unchanged.
- Back-to-back: START in the cycle after DONE with different weights. The second OUT reflects the new weights, and the first OUT holds until the second DONE.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Purpose  : State encoding, derived sizes and requantisation helper shared by
//            the CNN classifier engine and its convolution window.
// Revision : 1.0
// ============================================================================
package cnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_CONV        = 2'd1,
    S_FC          = 2'd2,
    S_ARGMAX_DONE = 2'd3
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int feat_of(input int fmap);
    return fmap * fmap;
  endfunction

  function automatic int waddr_w(input int nclass, input int fmap);
    return clog2_min1(nclass * fmap * fmap);
  endfunction

  function automatic int out_w(input int nclass);
    return clog2_min1(nclass);
  endfunction

  // ReLU, arithmetic shift, then clamp to the unsigned DW-bit feature range.
  function automatic logic [63:0] relu_sat(input logic signed [63:0] sum,
                                           input int shift, input int dw);
    logic signed [63:0] v;
    logic [63:0]        lim;
    lim      = (64'd1 << dw) - 64'd1;
    v        = (sum < 0) ? 64'sd0 : (sum >>> shift);
    relu_sat = ($unsigned(v) > lim) ? lim : $unsigned(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_conv_window.sv
`default_nettype none
// ============================================================================
// Module   : cnn_conv_window
// Purpose  : Combinational KxK signed-weight x unsigned-pixel MAC with
//            ReLU / shift / saturate to a DW-bit feature.
// Revision : 1.0
// ============================================================================
module cnn_conv_window
  import cnn_pkg::*;
#(
  parameter int K     = 5,
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int SHIFT = 0
) (
  input  logic [K*K*DW-1:0] i_win,
  input  logic [K*K*DW-1:0] i_wts,
  output logic [DW-1:0]     o_feat
);

  logic signed [ACC_W-1:0] w_wt;
  logic signed [ACC_W-1:0] w_px;
  logic signed [ACC_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    w_wt  = '0;
    w_px  = '0;
    for (int i = 0; i < K*K; i++) begin
      w_wt  = ACC_W'(signed'(i_wts[i*DW +: DW]));
      w_px  = signed'(ACC_W'(i_win[i*DW +: DW]));
      w_sum = w_sum + w_wt * w_px;
    end
  end

  assign o_feat = DW'(relu_sat(64'(w_sum), SHIFT, DW));

endmodule
`default_nettype wire

// File: rtl/cnn_classifier_engine.sv
`default_nettype none
// ============================================================================
// Module   : cnn_classifier_engine
// Purpose  : Conv + ReLU feature map, sequential FC layer and running argmax
//            with run-time loadable conv / FC weights.
// Revision : 1.0
// ============================================================================
module cnn_classifier_engine
  import cnn_pkg::*;
#(
  parameter int K      = 5,
  parameter int DW     = 8,
  parameter int FMAP   = 24,
  parameter int NCLASS = 10,
  parameter int ACC_W  = 32,
  parameter int SHIFT  = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_start,
  input  logic                             i_win_valid,
  output logic                             o_win_ready,
  input  logic [K*K*DW-1:0]                i_win,
  input  logic                             i_w_we,
  input  logic                             i_w_sel,
  input  logic [waddr_w(NCLASS,FMAP)-1:0]  i_w_addr,
  input  logic [DW-1:0]                    i_w_data,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [out_w(NCLASS)-1:0]         o_out
);

  localparam int c_feat = feat_of(FMAP);
  localparam int c_kk   = K * K;
  localparam int c_nfw  = NCLASS * c_feat;
  localparam int c_waw  = waddr_w(NCLASS, FMAP);
  localparam int c_ow   = out_w(NCLASS);
  localparam int c_fw   = clog2_min1(c_feat);
  localparam int c_cw   = clog2_min1(c_kk);

  state_t                  r_state, w_next;
  logic [DW-1:0]           r_cw   [c_kk];
  logic [DW-1:0]           r_fw   [c_nfw];
  logic [DW-1:0]           r_feat [c_feat];
  logic [c_fw-1:0]         r_cnt, r_j;
  logic [c_ow-1:0]         r_cls, r_best_idx, r_out;
  logic signed [ACC_W-1:0] r_acc, r_best;
  logic signed [ACC_W-1:0] w_acc_next, w_fc_prod;
  logic [c_kk*DW-1:0]      w_cw_flat;
  logic [DW-1:0]           w_conv_feat;
  logic [c_waw-1:0]        w_fc_idx;
  logic [c_ow-1:0]         w_final_idx;
  logic                    w_win_fire, w_last_feat, w_last_cls, w_take, w_wr_en;

  for (genvar g = 0; g < c_kk; g++) begin : g_cw_flat
    assign w_cw_flat[g*DW +: DW] = r_cw[g];
  end

  cnn_conv_window #(.K(K), .DW(DW), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_conv (
    .i_win  (i_win),
    .i_wts  (w_cw_flat),
    .o_feat (w_conv_feat)
  );

  assign o_win_ready = (r_state == S_CONV);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_ARGMAX_DONE);
  assign o_out       = r_out;

  assign w_win_fire  = i_win_valid && o_win_ready;
  assign w_last_feat = (r_j == c_fw'(c_feat - 1));
  assign w_last_cls  = (r_cls == c_ow'(NCLASS - 1));
  assign w_wr_en     = (r_state == S_IDLE) && i_w_we;
  assign w_fc_idx    = c_waw'(r_cls) * c_waw'(c_feat) + c_waw'(r_j);
  assign w_fc_prod   = ACC_W'(signed'(r_fw[w_fc_idx])) * signed'(ACC_W'(r_feat[r_j]));
  assign w_acc_next  = ((r_j == '0) ? '0 : r_acc) + w_fc_prod;
  // Strict compare keeps the lowest index on ties.
  assign w_take      = (r_cls == '0) || (w_acc_next > r_best);
  assign w_final_idx = w_take ? r_cls : r_best_idx;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:        if (i_start) w_next = S_CONV;
      S_CONV:        if (w_win_fire && (r_cnt == c_fw'(c_feat - 1))) w_next = S_FC;
      S_FC:          if (w_last_feat && w_last_cls) w_next = S_ARGMAX_DONE;
      S_ARGMAX_DONE: w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_j        <= '0;
      r_cls      <= '0;
      r_acc      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_out      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_cnt <= '0;
          r_j   <= '0;
          r_cls <= '0;
        end
        S_CONV: if (w_win_fire) r_cnt <= r_cnt + c_fw'(1);
        S_FC: begin
          r_acc <= w_acc_next;
          if (w_last_feat) begin
            r_j   <= '0;
            r_cls <= r_cls + c_ow'(1);
            if (w_take) begin
              r_best     <= w_acc_next;
              r_best_idx <= r_cls;
            end
            if (w_last_cls) r_out <= w_final_idx;
          end else begin
            r_j <= r_j + c_fw'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Weight and feature storage carry no reset so that loaded weights survive.
  always_ff @(posedge clk) begin
    if (w_wr_en && !i_w_sel && (32'(i_w_addr) < c_kk))
      r_cw[i_w_addr[c_cw-1:0]] <= i_w_data;
    if (w_wr_en && i_w_sel && (32'(i_w_addr) < c_nfw))
      r_fw[i_w_addr] <= i_w_data;
    if (w_win_fire)
      r_feat[r_cnt] <= w_conv_feat;
  end

endmodule
`default_nettype wire
